// File: rtl/run_length_detector_pkg.sv
// Shared types and constants for the run-length detector.
// State encoding and polarity-mode keys.
package run_length_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: reset/clr, then load1, then inc.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load1) begin
      q <= ONE;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/run_length_detector.sv
// Serial run-length detector: tracks runs of equal bits and
// flags when a run reaches a programmable threshold.
module run_length_detector
  import run_length_detector_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [CNT_W-1:0] thresh,
  input  logic [1:0]       mode,
  input  logic             clear_evt,
  output logic             out,
  output logic             rise,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic [EVT_W-1:0] evt_cnt
);

  state_t state;
  logic   out_q;
  logic   new_run;
  logic   extend;
  logic   permit;

  assign run_bit = (state == RUN1);

  // Any valid bit from IDLE, or a polarity flip, starts a new run.
  assign new_run = in_valid &
                   ((state == IDLE) | (in_bit != run_bit));
  assign extend  = in_valid & ~new_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      out_q <= 1'b0;
    end else begin
      out_q <= out;
      if (in_valid) begin
        state <= in_bit ? RUN1 : RUN0;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_run_len (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (extend),
    .load1(new_run),
    .q    (run_len)
  );

  always_comb begin
    permit = 1'b0;
    case (mode)
      MODE_BOTH:  permit = 1'b1;
      MODE_ONES:  permit = run_bit;
      MODE_ZEROS: permit = ~run_bit;
      default:    permit = 1'b0;
    endcase
  end

  assign out = (state != IDLE) &&
               (thresh != '0) &&
               (run_len >= thresh) &&
               permit;

  assign rise = out & ~out_q;

  sat_counter #(
    .W(EVT_W)
  ) u_evt_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clear_evt),
    .inc  (rise),
    .load1(1'b0),
    .q    (evt_cnt)
  );

endmodule
